// File: rtl/clint_arbiter_pkg.sv
// Shared types and constants for the CLINT round-robin arbiter.
package clint_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_W_DEF = 8;

  // An all-zero strobe marks a read access.
  function automatic logic is_read(input logic [15:0] wstrb);
    return wstrb == '0;
  endfunction

endpackage

// File: rtl/clint_arbiter_picker.sv
// Round-robin priority encoder: first set request after the last grant.
module clint_rr_picker
  import clint_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [LW-1:0]    grant,
  output logic             any
);

  int idx;

  // Walk from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant = '0;
    any   = |req;
    idx   = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (req[idx]) grant = LW'(idx);
    end
  end

endmodule

// File: rtl/clint_arbiter.sv
// Round-robin arbiter sharing one CLINT port among N_REQ requesters.
// Optional watchdog abort enabled by defining CLINT_ARB_TIMEOUT_EN.
module clint_arbiter
  import clint_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_REQ     = 2,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_address,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      req_err,
  output logic                      clint_valid,
  output logic [ADDR_W-1:0]         clint_address,
  output logic [DATA_W-1:0]         clint_wdata,
  output logic [DATA_W/8-1:0]       clint_wstrb,
  input  logic [DATA_W-1:0]         clint_rdata,
  input  logic                      clint_ready
);

  localparam int SW = DATA_W / 8;
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [LW-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  logic [LW-1:0]     pick;
  logic              any;

`ifdef CLINT_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

  clint_rr_picker #(
    .N_REQ (N_REQ),
    .LW    (LW)
  ) u_picker (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick),
    .any   (any)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    ready_d = '0;
    err_d   = 1'b0;
    valid_d = 1'b0;
`ifdef CLINT_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = BUSY;
          grant_d = pick;
          addr_d  = req_address[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
          wstrb_d = req_wstrb[int'(pick)*SW +: SW];
          valid_d = 1'b1;
`ifdef CLINT_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        valid_d = 1'b1;
        if (clint_ready) begin
          state_d          = DONE;
          rdata_d          = clint_rdata;
          ready_d[grant_q] = 1'b1;
          valid_d          = 1'b0;
        end
`ifdef CLINT_ARB_TIMEOUT_EN
        // Counter would saturate this cycle: abort with an error.
        else if (cnt_q == CNT_LAST) begin
          state_d          = DONE;
          rdata_d          = '1;
          err_d            = 1'b1;
          ready_d[grant_q] = 1'b1;
          valid_d          = 1'b0;
          cnt_d            = '1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= LW'(N_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef CLINT_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      valid_q <= valid_d;
`ifdef CLINT_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign clint_valid   = valid_q;
  assign clint_address = addr_q;
  assign clint_wdata   = wdata_q;
  assign clint_wstrb   = wstrb_q;
  assign req_rdata     = rdata_q;
  assign req_ready     = ready_q;
  assign req_err       = err_q;

endmodule

// File: tb/tb_clint_arbiter.sv
// Self-checking bench for clint_arbiter with a round-robin reference model.
module tb_clint_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    req_ready;
  logic            req_err;
  logic            clint_valid;
  logic [AW-1:0]   clint_address;
  logic [DW-1:0]   clint_wdata;
  logic [SW-1:0]   clint_wstrb;
  logic [DW-1:0]   clint_rdata;
  logic            clint_ready;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_addr  [N];
  logic [DW-1:0] m_wdata [N];
  logic [SW-1:0] m_wstrb [N];
  int            m_last;

  clint_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .N_REQ     (N),
    .TIMEOUT_W (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_address   (req_address),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .req_rdata     (req_rdata),
    .req_ready     (req_ready),
    .req_err       (req_err),
    .clint_valid   (clint_valid),
    .clint_address (clint_address),
    .clint_wdata   (clint_wdata),
    .clint_wstrb   (clint_wstrb),
    .clint_rdata   (clint_rdata),
    .clint_ready   (clint_ready)
  );

  always #5 clk = ~clk;

  // Spec rule: first requesting index after last, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i]            = v;
    req_address[i*AW +: AW] = a;
    req_wdata[i*DW +: DW]   = d;
    req_wstrb[i*SW +: SW]   = s;
    m_addr[i]  = a;
    m_wdata[i] = d;
    m_wstrb[i] = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    req_valid   = '0;
    req_address = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    clint_rdata = '0;
    clint_ready = 1'b0;
    m_last      = N - 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_busy(output int cyc);
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clint_valid) begin
        cyc = i + 1;
        return;
      end
    end
  endtask

  task automatic finish_txn(input int delay, input logic [DW-1:0] d,
                            output logic [N-1:0] rdy,
                            output logic [DW-1:0] rd, output logic e);
    repeat (delay - 1) @(negedge clk);
    clint_ready = 1'b1;
    clint_rdata = d;
    @(negedge clk);
    clint_ready = 1'b0;
    rdy = req_ready;
    rd  = req_rdata;
    e   = req_err;
  endtask

  task automatic test_reset();
    logic [N-1:0] rdy;
    req_valid = '1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (clint_valid !== 1'b0 || req_ready !== '0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got v=%b r=%b e=%b need 0 0 0",
               clint_valid, req_ready, req_err);
    end
    checks++;
    if (clint_address !== '0 || clint_wdata !== '0 ||
        clint_wstrb !== '0 || req_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h w=%h s=%h r=%h need zeros",
               clint_address, clint_wdata, clint_wstrb, req_rdata);
    end
    do_reset();
    @(negedge clk);
    rdy = req_ready;
    checks++;
    if (clint_valid !== 1'b0 || rdy !== '0) begin
      errors++;
      $display("FAIL reset_idle got v=%b r=%b need 0 0", clint_valid, rdy);
    end
  endtask

  task automatic test_single_read();
    int cyc;
    logic [N-1:0] rdy;
    logic [DW-1:0] rd;
    logic e;
    do_reset();
    set_req(0, 1'b1, 32'h0000_BFF8, 32'h0, 4'h0);
    wait_busy(cyc);
    checks++;
    if (cyc !== 1 || clint_address !== 32'h0000_BFF8 || clint_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL read_issue got cyc=%0d a=%h s=%h need 1 0000bff8 0",
               cyc, clint_address, clint_wstrb);
    end
    finish_txn(1, 32'h0000_1234, rdy, rd, e);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (rdy !== 2'b01 || rd !== 32'h0000_1234 || e !== 1'b0) begin
      errors++;
      $display("FAIL read_done got r=%b d=%h e=%b need 01 00001234 0", rdy, rd, e);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || clint_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse got r=%b v=%b need 00 0", req_ready, clint_valid);
    end
  endtask

  task automatic test_contention();
    int cyc;
    int g;
    logic [N-1:0] rdy;
    logic [DW-1:0] rd;
    logic e;
    do_reset();
    set_req(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
    for (int t = 0; t < 4; t++) begin
      g = rr_pick(m_last, req_valid);
      wait_busy(cyc);
      checks++;
      if (cyc !== ((t == 0) ? 1 : 2) || clint_address !== m_addr[g]) begin
        errors++;
        $display("FAIL contend_grant%0d got cyc=%0d a=%h need %0d %h", t,
                 cyc, clint_address, (t == 0) ? 1 : 2, m_addr[g]);
      end
      finish_txn(1, 32'(t), rdy, rd, e);
      checks++;
      if (rdy !== N'(1 << g) || rd !== 32'(t)) begin
        errors++;
        $display("FAIL contend_ready%0d got r=%b d=%h need %b %h", t, rdy, rd,
                 N'(1 << g), 32'(t));
      end
      m_last = g;
    end
    req_valid = '0;
  endtask

  task automatic test_write();
    int cyc;
    do_reset();
    set_req(1, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF);
    wait_busy(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (clint_valid !== 1'b1 || clint_address !== 32'h0000_4000 ||
          clint_wdata !== 32'hDEAD_BEEF || clint_wstrb !== 4'hF) begin
        errors++;
        $display("FAIL write_hold%0d got v=%b a=%h w=%h s=%h", i, clint_valid,
                 clint_address, clint_wdata, clint_wstrb);
      end
      if (i < 4) @(negedge clk);
    end
    clint_ready = 1'b1;
    @(negedge clk);
    clint_ready = 1'b0;
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (req_ready !== 2'b10 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL write_done got r=%b e=%b need 10 0", req_ready, req_err);
    end
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    logic [N-1:0] rdy;
    logic [DW-1:0] rd;
    logic e;
    do_reset();
    set_req(1, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
    wait_busy(cyc);
    reset = 1'b0;
    #1;
    checks++;
    if (clint_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got v=%b need 0", clint_valid);
    end
    set_req(0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
    clint_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL rst_no_ready got r=%b need 00", req_ready);
    end
    clint_ready = 1'b0;
    reset = 1'b1;
    wait_busy(cyc);
    checks++;
    if (cyc !== 1 || clint_address !== 32'h0000_0400) begin
      errors++;
      $display("FAIL rst_regrant got cyc=%0d a=%h need 1 00000400", cyc, clint_address);
    end
    finish_txn(2, 32'h55, rdy, rd, e);
    checks++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL rst_first got r=%b need 01", rdy);
    end
    req_valid = '0;
  endtask

  task automatic test_valid_drop();
    int cyc;
    logic [N-1:0] rdy;
    logic [DW-1:0] rd;
    logic e;
    do_reset();
    set_req(1, 1'b1, 32'h0000_0500, 32'h0000_0007, 4'h3);
    wait_busy(cyc);
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (clint_valid !== 1'b1 || clint_address !== 32'h0000_0500) begin
      errors++;
      $display("FAIL drop_hold got v=%b a=%h need 1 00000500", clint_valid, clint_address);
    end
    finish_txn(2, 32'hCAFE, rdy, rd, e);
    checks++;
    if (rdy !== 2'b10 || rd !== 32'hCAFE) begin
      errors++;
      $display("FAIL drop_ready got r=%b d=%h need 10 0000cafe", rdy, rd);
    end
  endtask

  task automatic test_random();
    int cyc;
    int g;
    int dly;
    logic [N-1:0] rdy;
    logic [DW-1:0] rd;
    logic [DW-1:0] d;
    logic e;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(1) == 1 || req_valid == '0))
          set_req(i, 1'b1, $urandom, $urandom, SW'($urandom));
      end
      g = rr_pick(m_last, req_valid);
      wait_busy(cyc);
      checks++;
      if (cyc < 0 || clint_address !== m_addr[g] || clint_wdata !== m_wdata[g] ||
          clint_wstrb !== m_wstrb[g]) begin
        errors++;
        $display("FAIL rand_issue%0d got cyc=%0d a=%h w=%h s=%h need g=%0d a=%h",
                 t, cyc, clint_address, clint_wdata, clint_wstrb, g, m_addr[g]);
      end
      dly = $urandom_range(4, 1);
      d   = $urandom;
      finish_txn(dly, d, rdy, rd, e);
      checks++;
      if (rdy !== N'(1 << g) || rd !== d || e !== 1'b0) begin
        errors++;
        $display("FAIL rand_done%0d got r=%b d=%h e=%b need %b %h 0", t, rdy, rd, e,
                 N'(1 << g), d);
      end
      req_valid[g] = 1'b0;
      m_last = g;
    end
    req_valid = '0;
  endtask

`ifdef CLINT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    int busy;
    do_reset();
    set_req(1, 1'b1, 32'h0000_0600, 32'h0, 4'h0);
    wait_busy(cyc);
    busy = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != '0) break;
      busy++;
    end
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (busy !== 15 || req_ready !== 2'b10 || req_err !== 1'b1 ||
        req_rdata !== 32'hFFFF_FFFF || clint_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout got busy=%0d r=%b e=%b d=%h v=%b need 15 10 1 ffffffff 0",
               busy, req_ready, req_err, req_rdata, clint_valid);
    end
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_0700, 32'h0, 4'h0);
    wait_busy(cyc);
    repeat (14) @(negedge clk);
    clint_ready = 1'b1;
    clint_rdata = 32'h1357;
    @(negedge clk);
    clint_ready = 1'b0;
    req_valid = '0;
    checks++;
    if (req_ready !== 2'b01 || req_err !== 1'b0 || req_rdata !== 32'h1357) begin
      errors++;
      $display("FAIL timeout_edge got r=%b e=%b d=%h need 01 0 00001357",
               req_ready, req_err, req_rdata);
    end
  endtask
`else
  task automatic test_timeout();
    int cyc;
    logic [N-1:0] rdy;
    logic [DW-1:0] rd;
    logic e;
    do_reset();
    set_req(1, 1'b1, 32'h0000_0600, 32'h0, 4'h0);
    wait_busy(cyc);
    repeat (40) @(negedge clk);
    checks++;
    if (clint_valid !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL no_timeout got v=%b r=%b need 1 00", clint_valid, req_ready);
    end
    finish_txn(1, 32'h2468, rdy, rd, e);
    req_valid = '0;
    checks++;
    if (rdy !== 2'b10 || e !== 1'b0 || rd !== 32'h2468) begin
      errors++;
      $display("FAIL no_timeout_done got r=%b e=%b d=%h need 10 0 00002468", rdy, e, rd);
    end
  endtask
`endif

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_address = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    clint_rdata = '0;
    clint_ready = 1'b0;
    m_last      = N - 1;
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_reset_mid_busy();
    test_valid_drop();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_arbiter.md
# clint_arbiter

Round-robin arbiter that shares one CLINT native-bus slave port (valid/address/wdata/wstrb/rdata/ready) among N_REQ requesters, typically one per hart plus a debug/DMA master. It sits between the core-side bus splitters and the CLINT. It serialises accesses with a registered-grant state machine, holding one transaction outstanding at a time. An optional watchdog aborts transactions the CLINT never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width per requester and toward the CLINT
- DATA_W, 32, data width; wstrb width is DATA_W/8
- N_REQ, 2, number of requesters (≥1)
- TIMEOUT_W, 8, watchdog counter width; only used with CLINT_ARB_TIMEOUT_EN

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request
- req_address  in  N_REQ*ADDR_W  flattened; requester i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  flattened, same slicing
- req_wstrb  in  N_REQ*DATA_W/8  flattened; all-zero = read
- req_rdata  out  DATA_W  shared read data; valid only with a req_ready bit
- req_ready  out  N_REQ  one-hot completion pulse
- req_err  out  1  timeout flag, qualified by req_ready
- clint_valid  out  1  request to CLINT
- clint_address  out  ADDR_W  latched address of granted requester
- clint_wdata  out  DATA_W  latched write data
- clint_wstrb  out  DATA_W/8  latched strobes
- clint_rdata  in  DATA_W  CLINT read data
- clint_ready  in  1  CLINT acknowledge

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req_valid bit is set, choose grant g as the first set bit searching from (last+1) mod N_REQ upward with wrap. Latch g and requester g's address/wdata/wstrb. Go to BUSY. With no request, stay in IDLE.
- BUSY: clint_valid=1 with latched fields held stable. On clint_ready=1, capture clint_rdata into rdata register and go to DONE.
- DONE: req_ready[g]=1 and req_rdata=captured data for exactly one cycle. Set last=g. Return to IDLE.
- Requesters must hold valid and their fields stable until their ready pulse. A requester dropping valid during BUSY is ignored: the latched transaction completes and its ready pulse is still issued.
- Non-granted requesters see req_ready=0 and wait; no request is lost.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,…,N_REQ-1,0,…
- N_REQ=1: pointer logic degenerates; grant is always 0.
- Reset values: state=IDLE, last=N_REQ-1 (requester 0 wins first), clint_valid=0, clint_address/wdata/wstrb=0, req_ready=0, req_rdata=0, req_err=0.
- Reset asserted mid-transaction aborts immediately. No ready pulse is issued and clint_valid drops asynchronously.

## Timing
- All outputs are registered; no combinational path from req_* or clint_ready to any output.
- Request sampled in IDLE at cycle 0 → clint_valid high in cycle 1.
- clint_ready high in cycle k (k≥1) → req_ready pulse in cycle k+1 → IDLE in cycle k+2.
- Minimum latency is 2 cycles from valid to ready, followed by 1 IDLE cycle. Peak throughput is therefore one transaction per 3 cycles.
- Requester deasserts valid in the cycle after its ready pulse, so IDLE never re-grants a completed request.
- Simultaneous new requests while BUSY/DONE are only considered in the next IDLE.

## Configuration
- CLINT_ARB_TIMEOUT_EN defined: a TIMEOUT_W-bit counter clears on entry to BUSY and increments each BUSY cycle without clint_ready.
  - On reaching all-ones, the transaction aborts: clint_valid drops, DONE is entered with req_rdata={DATA_W{1'b1}} and req_err=1 alongside req_ready[g].
  - clint_ready on the same cycle the counter saturates takes priority as a normal completion.
- CLINT_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely, req_err is tied 0, and no counter is built.

## Structure
- Shared package/header: state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2; default TIMEOUT_W; read-strobe convention (wstrb==0 means read).
- One natural sub-module: clint_rr_picker, a combinational round-robin priority encoder (inputs: req vector, last pointer; outputs: grant index, any).

## Test plan
- Single read: N_REQ=2, req0 reads 0xBFF8; CLINT acks in cycle 1 with 0x0000_1234 → req_ready=2'b01 in cycle 2, req_rdata=0x0000_1234, req_err=0.
- Contention: req0 and req1 valid together from reset → req0 granted first, then req1. Repeat the pair → order 0,1,0,1.
- Write pass-through: req1 writes 0x4000 with wdata 0xDEAD_BEEF and wstrb 4'hF → clint_address/wdata/wstrb match and stay stable through a 5-cycle clint_ready delay.
- Reset mid-BUSY: assert reset with clint_valid=1 → clint_valid=0 immediately and no req_ready pulse. After release, req0 is granted first.
- Valid dropped early: req1 deasserts valid during BUSY → transaction still issued, and req_ready[1] still pulses.
- Timeout (CLINT_ARB_TIMEOUT_EN, TIMEOUT_W=4): clint_ready never asserted → ready and req_err pulse after 15 BUSY cycles, with req_rdata=0xFFFF_FFFF.
